instr_fetch_unit: RTL and testbench

- Fetch controller that sits directly downstream of the PC register in the IF stage.
- Takes the current word-addressed PC and issues one request at a time to instruction memory, using a req/gnt then rvalid handshake.
- Buffers the returned instruction and presents it to decode with a valid/ready handshake.
- Emits pc_advance, the PC register's advance enable. Also handles redirect flushes and memory timeouts.

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF-stage fetch controller: one outstanding imem request,
// instruction buffering toward decode, PC advance, flush drain and response timeout.
module instr_fetch_unit #(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   pc_in,
  output logic            pc_advance,
  input  logic            flush,
  output logic            imem_req,
  output logic [AW-1:0]   imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_out,
  output logic [AW-1:0]   instr_pc,
  output logic            fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, ERR} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0] instr_out_q, instr_out_d;
  logic [AW-1:0]   instr_pc_q, instr_pc_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fetch_err_q, fetch_err_d;
  logic [CW-1:0]   cnt_inc;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    cnt_inc     = (wait_cnt_q == TMO) ? wait_cnt_q : wait_cnt_q + 1'b1;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem_gnt) begin
          wait_cnt_d = '0;
          if (flush) begin
            state_d = DRAIN;
          end else begin
            instr_pc_d = pc_in;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        wait_cnt_d = cnt_inc;
        // A flush turns the in-flight response into garbage that must still be absorbed.
        if (flush) begin
          state_d = imem_rvalid ? REQ : DRAIN;
        end else if (imem_rvalid) begin
          instr_out_d = imem_rdata;
          state_d     = HOLD;
        end else if (wait_cnt_q == TMO) begin
          state_d = ERR;
        end
      end
      HOLD: begin
        if (flush || instr_ready) state_d = REQ;
      end
      DRAIN: begin
        wait_cnt_d = cnt_inc;
        if (imem_rvalid) begin
          state_d = REQ;
        end else if (!flush && wait_cnt_q == TMO) begin
          state_d = ERR;
        end
      end
      ERR: begin
        if (flush) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
    instr_valid_d = (state_d == HOLD);
    fetch_err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      instr_out_q   <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = imem_req ? pc_in : '0;
  assign pc_advance  = (state_q == HOLD) && instr_ready && !flush;
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scenarios plus randomized fetch traffic against
// a PC-register / memory reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_adv    = 0;
  logic        last_adv = 1'b0;
  logic        last_fl  = 1'b0;
  logic [31:0] flush_tgt = 32'h0;

  instr_fetch_unit #(.XLEN(32), .AW(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_advance(pc_advance), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  // PC register model: loads the redirect target after a flush, steps on pc_advance.
  task automatic pc_step();
    if (last_fl) pc_in = flush_tgt;
    else if (last_adv) pc_in = pc_in + 32'd1;
  endtask

  task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic fl, input logic [31:0] tgt);
    @(negedge clk);
    pc_step();
    imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy; flush = fl;
    if (fl) flush_tgt = tgt;
    #1;
    last_adv = pc_advance;
    last_fl  = fl;
    if (pc_advance) n_adv++;
  endtask

  task automatic clear_inputs();
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0; flush = 0;
    pc_in = 0; last_adv = 0; last_fl = 0;
  endtask

  logic        out_pend, out_stale, rv, g, fl, rdy;
  int          out_cnt, n_acc;
  logic [31:0] out_addr;

  initial begin
    rst = 1'b0;
    clear_inputs();

    // Reset state
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_req", imem_req, 0);     check("rst_valid", instr_valid, 0);
    check("rst_adv", pc_advance, 0);   check("rst_err", fetch_err, 0);
    check("rst_out", instr_out, 0);    check("rst_pc", instr_pc, 0);
    check("rst_addr", imem_addr, 0);
    @(negedge clk); rst = 1'b1; #1;
    check("idle_req", imem_req, 0);

    // Zero-wait fetch
    cyc(1, 0, 0, 1, 0, 0);
    check("zw_req", imem_req, 1);      check("zw_addr", imem_addr, 0);
    cyc(0, 1, 32'h13, 1, 0, 0);
    check("zw_wait_req", imem_req, 0); check("zw_wait_valid", instr_valid, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("zw_valid", instr_valid, 1); check("zw_out", instr_out, 32'h13);
    check("zw_pc", instr_pc, 0);       check("zw_adv", pc_advance, 1);
    cyc(1, 0, 0, 0, 0, 0);
    check("zw_next_req", imem_req, 1); check("zw_next_addr", imem_addr, 1);
    check("zw_adv_once", n_adv, 1);

    // Decode backpressure
    cyc(0, 1, 32'h1111, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("bp_valid", instr_valid, 1); check("bp_out", instr_out, 32'h1111);
      check("bp_pc", instr_pc, 1);       check("bp_adv", pc_advance, 0);
      check("bp_req", imem_req, 0);
    end
    cyc(0, 0, 0, 1, 0, 0);
    check("bp_release_adv", pc_advance, 1);
    check("bp_adv_count", n_adv, 2);

    // Flush while waiting
    cyc(1, 0, 0, 0, 0, 0);
    check("fw_addr", imem_addr, 2);
    cyc(0, 0, 0, 0, 1, 32'h40);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("fw_drain_req", imem_req, 0); check("fw_drain_valid", instr_valid, 0);
    end
    cyc(0, 1, 32'hdeadbeef, 0, 0, 0);
    check("fw_stale_valid", instr_valid, 0);

    // Flush coinciding with grant
    cyc(1, 0, 0, 0, 1, 32'h80);
    check("fg_req", imem_req, 1);      check("fg_addr", imem_addr, 32'h40);
    cyc(0, 0, 0, 1, 0, 0);
    check("fg_drain_req", imem_req, 0); check("fg_drain_valid", instr_valid, 0);
    check("fg_drain_adv", pc_advance, 0);
    cyc(0, 1, 32'hbad0bad0, 1, 0, 0);
    check("fg_disc_valid", instr_valid, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("fg_new_addr", imem_addr, 32'h80); check("fg_new_valid", instr_valid, 0);
    cyc(0, 1, 32'h2222, 1, 0, 0);

    // Flush in HOLD together with ready
    cyc(0, 0, 0, 1, 1, 32'hc0);
    check("fh_valid", instr_valid, 1); check("fh_adv", pc_advance, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("fh_valid_drop", instr_valid, 0); check("fh_req", imem_req, 1);
    check("fh_addr", imem_addr, 32'hc0);

    // Timeout: wait_cnt walks 0..15, error registered after the last WAIT cycle
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("to_wait_err", fetch_err, 0); check("to_wait_req", imem_req, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("to_err", fetch_err, 1);     check("to_err_req", imem_req, 0);
      check("to_err_valid", instr_valid, 0);
    end
    cyc(0, 0, 0, 0, 1, 32'h100);
    check("to_flush_err", fetch_err, 1);
    cyc(1, 0, 0, 0, 0, 0);
    check("to_clr_err", fetch_err, 0); check("to_clr_req", imem_req, 1);
    check("to_clr_addr", imem_addr, 32'h100);
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h3333, 0, 0, 0);
    check("to_edge_err", fetch_err, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("to_edge_valid", instr_valid, 1); check("to_edge_out", instr_out, 32'h3333);
    check("to_edge_pc", instr_pc, 32'h100); check("to_edge_err2", fetch_err, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("to_edge_adv", pc_advance, 1);

    // Asynchronous reset while holding an instruction
    cyc(1, 0, 0, 0, 0, 0);
    check("ar_addr", imem_addr, 32'h101);
    cyc(0, 1, 32'h4444, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("ar_hold_valid", instr_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("ar_valid_now", instr_valid, 0); check("ar_req_now", imem_req, 0);
    clear_inputs();
    cyc(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hdeadbeef; #1;
    check("ar_idle_req", imem_req, 0);
    cyc(1, 0, 0, 1, 0, 0);
    check("ar_restart_req", imem_req, 1); check("ar_restart_addr", imem_addr, 0);
    check("ar_restart_valid", instr_valid, 0);
    cyc(0, 1, 32'h55, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("ar_fetch_out", instr_out, 32'h55); check("ar_fetch_adv", pc_advance, 1);

    // Randomized traffic against the memory and PC-register model
    @(negedge clk); rst = 1'b0; clear_inputs();
    @(negedge clk); rst = 1'b1;
    out_pend = 0; out_stale = 0; out_cnt = 0; out_addr = 0; n_acc = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pc_step();
      #1;
      rv  = out_pend && (out_cnt == 0);
      g   = imem_req && ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (fl) flush_tgt = $urandom & 32'hffff;
      imem_gnt = g; imem_rvalid = rv; instr_ready = rdy; flush = fl;
      imem_rdata = out_stale ? 32'hdeadbeef : mem_data(out_addr);
      #1;
      if (imem_req) check("rnd_addr", imem_addr, pc_in);
      check("rnd_adv", pc_advance, instr_valid && rdy && !fl);
      check("rnd_err", fetch_err, 0);
      if (instr_valid) begin
        check("rnd_pc", instr_pc, pc_in);
        check("rnd_data", instr_out, mem_data(pc_in));
        check("rnd_no_stale", instr_out == 32'hdeadbeef, 0);
      end
      if (pc_advance) n_acc++;
      if (out_pend) begin
        if (rv) out_pend = 0;
        else out_cnt--;
      end
      if (imem_req && g) begin
        out_pend  = 1;
        out_cnt   = $urandom_range(0, 7);
        out_addr  = imem_addr;
        out_stale = fl;
      end else if (fl && out_pend) begin
        out_stale = 1;
      end
      last_adv = pc_advance;
      last_fl  = fl;
    end
    check("rnd_progress", n_acc >= 50, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
